axil_master_param: RTL
======================

Name: axil_master_param

Overview:
- Parametrised, protocol-correct AXI4-Lite master; successor to the single-tick 8-bit master.
- Turns a simple request/acknowledge command interface into AXI-Lite read and write transactions:
  - independent read and write engines;
  - configurable address and data width, byte strobes, full 2-bit response capture;
  - per-engine response-timeout watchdog.
- Sits between local control logic (register sequencers, test drivers) and the AXI-Lite interconnect/slaves.

Parameters:
- ADDR_W, 32: address width of read_address, write_address and the command ports.
- DATA_W, 32: data width; must be a multiple of 8.
- STRB_W, DATA_W/8: derived byte-strobe width; not overridable.
- TIMEOUT_CYCLES, 1024: cycles waited for a READY or VALID before the timeout flag is raised; 0 disables the watchdog.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- rd_req  in  1  read command valid
- rd_addr  in  ADDR_W  read command address
- rd_req_ready  out  1  read engine idle, can accept a command
- rd_done  out  1  one-cycle pulse, read complete
- rd_data  out  DATA_W  captured RDATA, held until next rd_done
- rd_resp  out  2  captured RRESP
- rd_timeout  out  1  sticky read timeout flag
- wr_req  in  1  write command valid
- wr_addr  in  ADDR_W  write command address
- wr_data  in  DATA_W  write command data
- wr_strb  in  STRB_W  write command byte strobes
- wr_req_ready  out  1  write engine idle
- wr_done  out  1  one-cycle pulse, write complete
- wr_resp  out  2  captured BRESP
- wr_timeout  out  1  sticky write timeout flag
- read_address  out  ADDR_W  ARADDR
- AR_VALID  out  1  ARVALID
- AR_READY  in  1  ARREADY
- data_read  in  DATA_W  RDATA
- R_RESP  in  2  RRESP
- R_VALID  in  1  RVALID
- R_READY  out  1  RREADY
- write_address  out  ADDR_W  AWADDR
- AW_VALID  out  1  AWVALID
- AW_READY  in  1  AWREADY
- data_write  out  DATA_W  WDATA
- W_STRB  out  STRB_W  WSTRB
- W_VALID  out  1  WVALID
- W_READY  in  1  WREADY
- BRESPONSE  in  2  BRESP
- B_VALID  in  1  BVALID
- B_READY  out  1  BREADY

Behaviour:
- Reset (synchronous, active-high): both engines return to IDLE.
  - All VALID/READY outputs, done pulses, timeout flags, data, resp and address outputs go to 0.
  - rd_req_ready and wr_req_ready are 1 in the first cycle after rst deasserts.
  - rst mid-transaction aborts it immediately with no done pulse.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: rd_req_ready=1. On rd_req, latch rd_addr into read_address and go to R_ADDR; AR_VALID=1 on the next cycle.
  - R_ADDR: AR_VALID held, read_address stable, until AR_READY is sampled high; then AR_VALID=0, go to R_DATA.
  - R_DATA: R_READY=1. On R_VALID&R_READY, capture data_read into rd_data and R_RESP into rd_resp, pulse rd_done the next cycle, return to R_IDLE.
  - Minimum latency, rd_req to rd_done: 3 cycles with AR_READY and R_VALID already high.
  - rd_data/rd_resp hold their values until the next capture; they are never cleared between transactions.
- Write FSM, states W_IDLE, W_ADDR_DATA, W_RESP:
  - W_IDLE: wr_req_ready=1. On wr_req, latch address, data and strobes; go to W_ADDR_DATA; AW_VALID=W_VALID=1 on the next cycle.
  - W_ADDR_DATA: AW and W complete independently. Internal aw_done/w_done flags set on each handshake, and the corresponding VALID drops the next cycle. When both are done (same cycle allowed), go to W_RESP.
  - W_RESP: B_READY=1. On B_VALID, capture BRESPONSE into wr_resp, pulse wr_done, return to W_IDLE.
- VALID is never deasserted before its handshake, and payload never changes while VALID=1.
- Commands presented while an engine is not ready are ignored; the requester must hold them.
- Read and write engines run fully concurrently. Simultaneous rd_req and wr_req are both accepted in the same cycle.
- Watchdog, one per engine:
  - The counter clears on entry to any non-IDLE state and on each handshake, and increments every other cycle spent in a non-IDLE state.
  - At TIMEOUT_CYCLES it sets the engine's sticky timeout flag; the transaction keeps waiting (no VALID drop).
  - The flag clears only on rst or on acceptance of the next command on that engine.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it saturates, no wrap.

Decomposition:
- Shared package axil_pkg:
  - response code constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - read and write state encodings, one-hot, 3 bits each.
- Sub-module axil_watchdog (params TIMEOUT_CYCLES; ports clk, rst, active, kick, expired), instantiated twice.

Test Plan:
- Read with AR_READY=1 and R_VALID one cycle after the AR handshake, data_read=32'hDEADBEEF, R_RESP=00 -> rd_done pulses once, rd_data=32'hDEADBEEF, rd_resp=00, 3-cycle latency.
- Write with addr 32'h10, data 32'hA5A5_0000, strb 4'b1100; AW_READY at cycle 2, W_READY at cycle 5; BRESPONSE=10 -> AW_VALID drops after cycle 2 while W_VALID holds until cycle 5; B_READY only after both handshakes; wr_resp=10; wr_done pulses once.
- AR_READY held low for 20 cycles -> AR_VALID and read_address stable for all 20 cycles, no rd_done; release -> normal completion.
- TIMEOUT_CYCLES=8, B_VALID withheld -> wr_timeout=1 after 8 cycles in W_RESP; later B_VALID -> wr_done; next wr_req clears wr_timeout.
- Simultaneous rd_req and wr_req with all READYs high -> both complete independently, with correct data and responses on each channel.
- rst asserted while in W_ADDR_DATA -> next cycle AW_VALID=W_VALID=B_READY=0, wr_req_ready=1, no wr_done.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, engine state
// encodings and the watchdog counter sizing helper.
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_ADDR = 3'b010,
        R_DATA = 3'b100
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE      = 3'b001,
        W_ADDR_DATA = 3'b010,
        W_RESP      = 3'b100
    } wr_state_e;

    // A limit of 0 disables the watchdog but still needs a 1-bit counter.
    function automatic int unsigned wdt_cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Saturating wait counter: clears while idle or on a handshake (kick), counts
// every other active cycle, and reports when it has reached TIMEOUT_CYCLES.
module axil_watchdog
    import axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic kick,
    output logic expired
);

    localparam int unsigned CNT_W = wdt_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (!active || kick) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/axil_master_param.sv
// AXI4-Lite master with independent read and write engines driven by a
// request/acknowledge command interface, with per-engine response watchdogs.
module axil_master_param
    import axil_pkg::*;
#(
    parameter  int ADDR_W         = 32,
    parameter  int DATA_W         = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int STRB_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_req_ready,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_resp,
    output logic              rd_timeout,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    output logic              wr_req_ready,
    output logic              wr_done,
    output logic [1:0]        wr_resp,
    output logic              wr_timeout,
    output logic [ADDR_W-1:0] read_address,
    output logic              AR_VALID,
    input  logic              AR_READY,
    input  logic [DATA_W-1:0] data_read,
    input  logic [1:0]        R_RESP,
    input  logic              R_VALID,
    output logic              R_READY,
    output logic [ADDR_W-1:0] write_address,
    output logic              AW_VALID,
    input  logic              AW_READY,
    output logic [DATA_W-1:0] data_write,
    output logic [STRB_W-1:0] W_STRB,
    output logic              W_VALID,
    input  logic              W_READY,
    input  logic [1:0]        BRESPONSE,
    input  logic              B_VALID,
    output logic              B_READY
);

    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        rd_resp_q, rd_resp_d;
    logic              rd_done_q, rd_done_d;
    logic              rd_timeout_q, rd_timeout_d;
    logic              ar_hs, r_hs, rd_expired;

    wr_state_e         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
    logic [1:0]        wr_resp_q, wr_resp_d;
    logic              wr_done_q, wr_done_d;
    logic              wr_timeout_q, wr_timeout_d;
    logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              aw_hs, w_hs, b_hs, wr_expired;

    // Read engine
    always_comb begin
        rd_state_d   = rd_state_q;
        rd_addr_d    = rd_addr_q;
        rd_data_d    = rd_data_q;
        rd_resp_d    = rd_resp_q;
        rd_done_d    = 1'b0;
        rd_timeout_d = rd_timeout_q | rd_expired;
        ar_hs        = 1'b0;
        r_hs         = 1'b0;
        unique case (rd_state_q)
            R_IDLE: if (rd_req) begin
                rd_addr_d    = rd_addr;
                rd_timeout_d = 1'b0;
                rd_state_d   = R_ADDR;
            end
            R_ADDR: if (AR_READY) begin
                ar_hs      = 1'b1;
                rd_state_d = R_DATA;
            end
            R_DATA: if (R_VALID) begin
                r_hs       = 1'b1;
                rd_data_d  = data_read;
                rd_resp_d  = R_RESP;
                rd_done_d  = 1'b1;
                rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write engine: AW and W retire independently, in either order or together.
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_strb_d    = wr_strb_q;
        wr_resp_d    = wr_resp_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        wr_done_d    = 1'b0;
        wr_timeout_d = wr_timeout_q | wr_expired;
        aw_hs        = 1'b0;
        w_hs         = 1'b0;
        b_hs         = 1'b0;
        unique case (wr_state_q)
            W_IDLE: if (wr_req) begin
                wr_addr_d    = wr_addr;
                wr_data_d    = wr_data;
                wr_strb_d    = wr_strb;
                aw_done_d    = 1'b0;
                w_done_d     = 1'b0;
                wr_timeout_d = 1'b0;
                wr_state_d   = W_ADDR_DATA;
            end
            W_ADDR_DATA: begin
                aw_hs     = AW_VALID & AW_READY;
                w_hs      = W_VALID & W_READY;
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: if (B_VALID) begin
                b_hs       = 1'b1;
                wr_resp_d  = BRESPONSE;
                wr_done_d  = 1'b1;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q   <= R_IDLE;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            rd_resp_q    <= '0;
            rd_done_q    <= 1'b0;
            rd_timeout_q <= 1'b0;
            wr_state_q   <= W_IDLE;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_strb_q    <= '0;
            wr_resp_q    <= '0;
            wr_done_q    <= 1'b0;
            wr_timeout_q <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            rd_resp_q    <= rd_resp_d;
            rd_done_q    <= rd_done_d;
            rd_timeout_q <= rd_timeout_d;
            wr_state_q   <= wr_state_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_strb_q    <= wr_strb_d;
            wr_resp_q    <= wr_resp_d;
            wr_done_q    <= wr_done_d;
            wr_timeout_q <= wr_timeout_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    axil_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_wdt (
        .clk    (clk),
        .rst    (rst),
        .active (rd_state_q != R_IDLE),
        .kick   (ar_hs | r_hs),
        .expired(rd_expired)
    );

    axil_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_wdt (
        .clk    (clk),
        .rst    (rst),
        .active (wr_state_q != W_IDLE),
        .kick   (aw_hs | w_hs | b_hs),
        .expired(wr_expired)
    );

    // The flag shows in the very cycle the limit is reached, then stays sticky.
    assign rd_req_ready  = (rd_state_q == R_IDLE);
    assign rd_done       = rd_done_q;
    assign rd_data       = rd_data_q;
    assign rd_resp       = rd_resp_q;
    assign rd_timeout    = rd_timeout_q | rd_expired;
    assign read_address  = rd_addr_q;
    assign AR_VALID      = (rd_state_q == R_ADDR);
    assign R_READY       = (rd_state_q == R_DATA);

    assign wr_req_ready  = (wr_state_q == W_IDLE);
    assign wr_done       = wr_done_q;
    assign wr_resp       = wr_resp_q;
    assign wr_timeout    = wr_timeout_q | wr_expired;
    assign write_address = wr_addr_q;
    assign data_write    = wr_data_q;
    assign W_STRB        = wr_strb_q;
    assign AW_VALID      = (wr_state_q == W_ADDR_DATA) && !aw_done_q;
    assign W_VALID       = (wr_state_q == W_ADDR_DATA) && !w_done_q;
    assign B_READY       = (wr_state_q == W_RESP);

endmodule
